// File: rtl/i2c_sensor_slave.sv
// I2C target exposing a live temperature value (reg0/reg1, snapshotted per
// transaction) plus a small byte-wide register file with a write strobe.
`timescale 1ns/1ps

module i2c_sensor_slave #(
  parameter logic [6:0]  I2C_ADDR = 7'h4B,
  parameter int unsigned NUM_REGS = 16,
  localparam int unsigned PTR_W   = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      temp,
  input  logic             scl,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             reg_wr,
  output logic [PTR_W-1:0] reg_wr_addr,
  output logic [7:0]       reg_wr_data,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RD_MACK,
    WAIT_STOP
  } state_e;

  logic             scl_m_q, scl_s_q, scl_p_q;
  logic             sda_m_q, sda_s_q, sda_p_q;
  logic             scl_rise, scl_fall, start_det, stop_det;

  state_e           state_q;
  logic [3:0]       bit_cnt_q;
  logic [7:0]       shreg_q;
  logic             rw_q;
  logic [PTR_W-1:0] ptr_q;
  logic [15:0]      snap_q;
  logic [7:0]       regs_q [NUM_REGS];
  logic             sda_oe_q;
  logic             reg_wr_q;
  logic [PTR_W-1:0] reg_wr_addr_q;
  logic [7:0]       reg_wr_data_q;

  logic [7:0]       byte_in;
  logic [7:0]       rd_byte;
  logic [PTR_W-1:0] ptr_inc;

  // Synchronisers are left unreset so a reset never fabricates bus edges.
  always_ff @(posedge clk) begin
    scl_m_q <= scl;
    scl_s_q <= scl_m_q;
    scl_p_q <= scl_s_q;
    sda_m_q <= sda_in;
    sda_s_q <= sda_m_q;
    sda_p_q <= sda_s_q;
  end

  assign scl_rise  = scl_s_q & ~scl_p_q;
  assign scl_fall  = ~scl_s_q & scl_p_q;
  assign start_det = scl_s_q & scl_p_q & sda_p_q & ~sda_s_q;
  assign stop_det  = scl_s_q & scl_p_q & ~sda_p_q & sda_s_q;

  assign byte_in = {shreg_q[6:0], sda_s_q};
  assign ptr_inc = ptr_q + PTR_W'(1);

  always_comb begin
    rd_byte = regs_q[ptr_q];
    if (ptr_q == '0) begin
      rd_byte = snap_q[15:8];
    end else if (ptr_q == PTR_W'(1)) begin
      rd_byte = snap_q[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      rw_q          <= 1'b0;
      ptr_q         <= '0;
      snap_q        <= '0;
      sda_oe_q      <= 1'b0;
      reg_wr_q      <= 1'b0;
      reg_wr_addr_q <= '0;
      reg_wr_data_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      reg_wr_q <= 1'b0;
      if (start_det) begin
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
      end else if (stop_det) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              shreg_q <= byte_in;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd8;
                if (state_q == ADDR) begin
                  if (byte_in[7:1] == I2C_ADDR) begin
                    snap_q  <= temp;
                    rw_q    <= byte_in[0];
                    state_q <= ADDR_ACK;
                  end else begin
                    state_q <= WAIT_STOP;
                  end
                end else if (state_q == PTR) begin
                  ptr_q   <= byte_in[PTR_W-1:0];
                  state_q <= PTR_ACK;
                end else begin
                  // reg0/reg1 are the read-only temperature bytes
                  if (ptr_q > PTR_W'(1)) begin
                    regs_q[ptr_q] <= byte_in;
                    reg_wr_q      <= 1'b1;
                    reg_wr_addr_q <= ptr_q;
                    reg_wr_data_q <= byte_in;
                  end
                  ptr_q   <= ptr_inc;
                  state_q <= WDATA_ACK;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          // bit_cnt 8: between 8th rise and 9th rise; 9: inside the ACK clock
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_fall && bit_cnt_q == 4'd8) begin
              sda_oe_q <= 1'b1;
            end else if (scl_rise && bit_cnt_q == 4'd8) begin
              bit_cnt_q <= 4'd9;
            end else if (scl_fall && bit_cnt_q == 4'd9) begin
              bit_cnt_q <= '0;
              sda_oe_q  <= 1'b0;
              if (state_q == ADDR_ACK && rw_q) begin
                state_q  <= RDATA;
                shreg_q  <= rd_byte;
                sda_oe_q <= ~rd_byte[7];
              end else if (state_q == ADDR_ACK) begin
                state_q <= PTR;
              end else begin
                state_q <= WDATA;
              end
            end
          end

          RDATA: begin
            if (scl_rise && bit_cnt_q != 4'd8) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                state_q  <= RD_MACK;
              end else begin
                shreg_q  <= {shreg_q[6:0], 1'b0};
                sda_oe_q <= ~shreg_q[6];
              end
            end
          end

          RD_MACK: begin
            if (scl_rise) begin
              if (!sda_s_q) begin
                ptr_q     <= ptr_inc;
                bit_cnt_q <= 4'd9;
              end else begin
                state_q <= WAIT_STOP;
              end
            end else if (scl_fall && bit_cnt_q == 4'd9) begin
              bit_cnt_q <= '0;
              shreg_q   <= rd_byte;
              sda_oe_q  <= ~rd_byte[7];
              state_q   <= RDATA;
            end
          end

          default: ;
        endcase
      end
    end
  end

  assign sda_oe      = sda_oe_q;
  assign reg_wr      = reg_wr_q;
  assign reg_wr_addr = reg_wr_addr_q;
  assign reg_wr_data = reg_wr_data_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_sensor_slave.sv
// Bench for i2c_sensor_slave: bit-banged I2C master plus a byte-level model
// of the register map, pointer and temperature snapshot.
`timescale 1ns/1ps

module tb_i2c_sensor_slave;

  localparam int Q = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] temp = 16'h0C80;
  logic        scl = 1'b1;
  logic        m_low = 1'b0;
  logic        sda_line;
  logic        sda_oe, reg_wr, busy;
  logic [3:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;

  assign sda_line = ~(sda_oe | m_low);

  i2c_sensor_slave #(.I2C_ADDR(7'h4B), .NUM_REGS(16)) dut (
    .clk(clk), .reset(reset), .temp(temp), .scl(scl), .sda_in(sda_line),
    .sda_oe(sda_oe), .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model
  logic [7:0]  m_regs [16];
  logic [3:0]  m_ptr = '0;
  logic [15:0] m_snap;
  logic [11:0] exp_wr[$];
  logic [11:0] act_wr[$];
  logic [7:0]  wdata [8];

  int pulse_run = 0;
  int max_run = 0;
  bit oe_seen = 1'b0;

  always @(negedge clk) begin
    if (reg_wr === 1'b1) begin
      act_wr.push_back({reg_wr_addr, reg_wr_data});
      pulse_run++;
      if (pulse_run > max_run) max_run = pulse_run;
    end else begin
      pulse_run = 0;
    end
    if (sda_oe === 1'b1) oe_seen = 1'b1;
  end

  task automatic i2c_start();
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack,
                           output logic oe_ack, output logic oe_after);
    for (int i = 7; i >= 0; i--) begin
      #Q m_low = ~b[i];
      #Q scl = 1'b1;
      #Q;
      #Q scl = 1'b0;
    end
    #10 m_low = 1'b0;
    #30 oe_ack = sda_oe;
    #10;
    #Q scl = 1'b1;
    #Q ack = sda_line;
    #Q scl = 1'b0;
    #40 oe_after = sda_oe;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d, output logic oe9);
    for (int i = 7; i >= 0; i--) begin
      #Q;
      #Q scl = 1'b1;
      #Q d[i] = sda_line;
      #Q scl = 1'b0;
    end
    #10 m_low = ~nack;
    #40;
    #Q scl = 1'b1;
    #Q oe9 = sda_oe;
    #Q scl = 1'b0;
    #10 m_low = 1'b0;
    #40;
  endtask

  task automatic compare_wr(input string tag);
    check({tag, "_nwr"}, act_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++)
      check({tag, "_wr"}, act_wr[i], exp_wr[i]);
    act_wr.delete();
    exp_wr.delete();
  endtask

  task automatic wr_txn(input string tag, input logic [7:0] ptr, input int n, input bit stop);
    logic ack, oa, ob;
    i2c_start();
    send_byte(8'h96, ack, oa, ob);
    check({tag, "_aack"}, ack, 1'b0);
    check({tag, "_aoe"}, oa, 1'b1);
    check({tag, "_arel"}, ob, 1'b0);
    send_byte(ptr, ack, oa, ob);
    check({tag, "_pack"}, ack, 1'b0);
    m_ptr = ptr[3:0];
    for (int i = 0; i < n; i++) begin
      send_byte(wdata[i], ack, oa, ob);
      check({tag, "_dack"}, ack, 1'b0);
      if (m_ptr >= 4'd2) begin
        m_regs[m_ptr] = wdata[i];
        exp_wr.push_back({m_ptr, wdata[i]});
      end
      m_ptr = m_ptr + 4'd1;
    end
    if (stop) i2c_stop();
    repeat (3) @(posedge clk);
    #1 compare_wr(tag);
    if (stop) check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic rd_txn(input string tag, input int n, input bit chg, input logic [15:0] new_temp);
    logic ack, oa, ob, oe9;
    logic [7:0] d, e;
    i2c_start();
    send_byte(8'h97, ack, oa, ob);
    m_snap = temp;
    check({tag, "_aack"}, ack, 1'b0);
    check({tag, "_aoe"}, oa, 1'b1);
    check({tag, "_busy1"}, busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      e = (m_ptr == 4'd0) ? m_snap[15:8] : (m_ptr == 4'd1) ? m_snap[7:0] : m_regs[m_ptr];
      read_byte(i == n - 1, d, oe9);
      if (chg && i == 0) temp = new_temp;
      check({tag, "_data"}, d, e);
      check({tag, "_rel9"}, oe9, 1'b0);
      if (i != n - 1) m_ptr = m_ptr + 4'd1;
    end
    i2c_stop();
    repeat (3) @(posedge clk);
    #1 check({tag, "_busy0"}, busy, 1'b0);
  endtask

  initial begin
    logic ack, oa, ob;
    logic [7:0] p;
    int n;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;

    repeat (4) @(posedge clk);
    #1;
    check("rst_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr", reg_wr, 1'b0);
    check("rst_waddr", reg_wr_addr, 4'h0);
    check("rst_wdata", reg_wr_data, 8'h00);
    @(negedge clk) reset = 1'b0;
    repeat (4) @(posedge clk);

    // temperature read
    temp = 16'h0C80;
    rd_txn("temp", 2, 1'b0, 16'h0);

    // write then read back through repeated START
    wdata[0] = 8'hA5; wdata[1] = 8'h3C;
    wr_txn("wr", 8'h05, 2, 1'b0);
    wr_txn("ptr", 8'h05, 0, 1'b0);
    rd_txn("rb", 2, 1'b0, 16'h0);

    // wrong address
    oe_seen = 1'b0;
    i2c_start();
    send_byte(8'hA0, ack, oa, ob);
    check("badaddr_nack", ack, 1'b1);
    send_byte(8'h55, ack, oa, ob);
    check("badaddr_nack2", ack, 1'b1);
    i2c_stop();
    repeat (3) @(posedge clk);
    #1;
    check("badaddr_oe", oe_seen, 1'b0);
    check("badaddr_nwr", act_wr.size(), 0);
    check("badaddr_busy", busy, 1'b0);

    // pointer wrap, reg0 write ignored
    wdata[0] = 8'h11; wdata[1] = 8'h22;
    wr_txn("wrap", 8'h0F, 2, 1'b1);
    rd_txn("wrap_rd", 1, 1'b0, 16'h0);

    // snapshot holds when temp changes mid-read
    temp = 16'h0C80;
    wr_txn("snp_ptr", 8'h00, 0, 1'b0);
    rd_txn("snap", 2, 1'b1, 16'h1900);

    // reset while driving SDA
    temp = 16'h0C80;
    wr_txn("rst_ptr", 8'h00, 0, 1'b1);
    i2c_start();
    send_byte(8'h97, ack, oa, ob);
    @(negedge clk);
    check("mid_oe_pre", sda_oe, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_oe_rel", sda_oe, 1'b0);
    check("mid_busy", busy, 1'b0);
    @(negedge clk) reset = 1'b0;
    m_ptr = '0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    i2c_stop();
    temp = 16'h2468;
    rd_txn("post_rst", 3, 1'b0, 16'h0);

    // randomized traffic
    for (int it = 0; it < 16; it++) begin
      temp = 16'($urandom);
      p = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++) wdata[i] = 8'($urandom);
        wr_txn("rnd_wr", p, n, 1'b1);
      end else begin
        if ($urandom_range(0, 1) == 1) wr_txn("rnd_ptr", p, 0, 1'b0);
        rd_txn("rnd_rd", $urandom_range(1, 4), 1'b0, 16'h0);
      end
    end

    check("wr_pulse_len", max_run, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_sensor_slave.md
I2C_SENSOR_SLAVE -- requirements
Module: i2c_sensor_slave

Interface
REQ-001 SHALL have parameter I2C_ADDR, default 7'h4B, the 7-bit target address.
REQ-002 SHALL have parameter NUM_REGS, default 16, the register count (power of 2, 4..256); PTR_W = clog2(NUM_REGS).
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: system clock, at least 16x SCL frequency.
REQ-005 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port temp, input, 16 bits: live temperature value, mapped to reg0 (MSB) and reg1 (LSB).
REQ-007 SHALL have port scl, input, 1 bit: I2C clock, asynchronous.
REQ-008 SHALL have port sda_in, input, 1 bit: I2C data as seen on the pin, asynchronous.
REQ-009 SHALL have port sda_oe, output, 1 bit: 1 drives SDA low; 0 releases SDA to the pull-up.
REQ-010 SHALL have port reg_wr, output, 1 bit: one-cycle write strobe.
REQ-011 SHALL have port reg_wr_addr, output, PTR_W bits: register index written.
REQ-012 SHALL have port reg_wr_data, output, 8 bits: byte written.
REQ-013 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-014 SHALL pass scl and sda_in through 2-FF synchronisers; all edge and condition detection SHALL use the synchronised values.
REQ-015 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-016 SHALL sample SDA on SCL rising edges and update sda_oe only on SCL falling edges, within 4 clk cycles of the pin edge.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK and WAIT_STOP.
REQ-018 SHALL, on START in any state (including a repeated START), enter ADDR and clear the bit counter.
REQ-019 SHALL, on STOP in any state, enter IDLE and drop sda_oe to 0 on the next clk.
REQ-020 SHALL receive the address byte MSB first as 7 address bits followed by R/W.
REQ-021 SHALL, on an address mismatch, enter WAIT_STOP, never assert sda_oe, and ignore the bus until the next START or STOP.
REQ-022 SHALL, on an address match, assert sda_oe from the 8th SCL falling edge to the 9th SCL falling edge (ACK).
REQ-023 SHALL, on an address match, snapshot temp into reg0/reg1 at the 8th SCL rising edge; all reads of reg0/reg1 in that transaction SHALL return the snapshot.
REQ-024 SHALL, on a write (R/W=0), take the first data byte as the pointer (modulo NUM_REGS, upper bits ignored), ACK it, and go to WDATA.
REQ-025 SHALL, in WDATA, capture each byte at its 8th rising edge, ACK it, and pulse reg_wr for one cycle with reg_wr_addr = ptr and reg_wr_data = byte.
REQ-026 SHALL, in WDATA, write the internal register file, then increment ptr.
REQ-027 SHALL treat writes to reg0/reg1 as read-only: ACKed, no reg_wr pulse, no storage, ptr still increments.
REQ-028 SHALL, on a read (R/W=1), shift out reg[ptr] MSB first with sda_oe = ~bit.
REQ-029 SHALL release SDA during the 9th bit of each read byte and sample the master ACK on the 9th rising edge.
REQ-030 SHALL, on master ACK (0), increment ptr and send the next byte.
REQ-031 SHALL, on master NACK (1), enter WAIT_STOP with SDA released.
REQ-032 SHALL wrap ptr from NUM_REGS-1 to 0 on every increment.
REQ-033 SHALL retain ptr across STOP and repeated START, so that a write-pointer / repeated-START / read sequence works.
REQ-034 SHALL hold reg_wr at 0 except for the single-cycle pulses defined in REQ-025.

Reset
REQ-035 SHALL, while reset is high at a clk edge, force state IDLE, ptr 0, reg2..regN-1 0, snapshot 0, sda_oe 0, reg_wr 0, reg_wr_addr 0, reg_wr_data 0, busy 0.
REQ-036 SHALL, after reset is asserted mid-transfer, release SDA on the next clk and ignore the bus until a new START.

Verification
REQ-037 Read temp: temp=16'h0C80; START, 0x97, read two bytes with ACK then NACK, STOP -> ACK at address, bytes 0x0C and 0x80, busy=0 after STOP.
REQ-038 Write then read back: START, 0x96, 0x05, 0xA5, 0x3C -> reg_wr pulses (5,A5) then (6,3C); repeated START, 0x96, 0x05, repeated START, 0x97, read two bytes -> 0xA5, 0x3C.
REQ-039 Wrong address: START, 0xA0, 0x55, STOP -> sda_oe stays 0 throughout, no reg_wr, busy=0 after STOP.
REQ-040 Wrap: pointer 15 (NUM_REGS=16), write 0x11, 0x22 -> reg_wr (15,0x11) only, both bytes ACKed; ptr=1 afterwards.
REQ-041 Snapshot: temp changes from 0x0C80 to 0x1900 between the MSB and LSB reads -> bytes read are 0x0C and 0x80.
REQ-042 Reset mid-read: assert reset while sda_oe=1 -> sda_oe=0 next clk; a subsequent full read returns correct data with ptr starting at 0.
